// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back types, imported by the
// write-back arbiter and the register file itself.
package regfile_pkg;

    localparam int REGISTER_FILE_SIZE = 32;
    localparam int REG_ID_W           = 6;
    localparam int DATA_W             = 32;

    typedef enum logic {
        WB_INIT,
        WB_RUN
    } wb_state_t;

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Drives the register file's single write port: zero-fills r1..r31 after reset,
// then arbitrates ALU and load write-backs with an anti-starvation override for the ALU.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int REGISTER_FILE_SIZE = regfile_pkg::REGISTER_FILE_SIZE,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_ID_W-1:0] alu_id,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_ID_W-1:0] mem_id,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_write_en,
    output logic [REG_ID_W-1:0] rf_write_id,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic                init_done
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t           state, next_state;
    logic [REG_ID_W-1:0] init_idx, next_idx;
    logic [CNT_W-1:0]    starve_cnt, next_cnt;
    logic                next_en, next_done;
    logic [REG_ID_W-1:0] next_id;
    logic [DATA_W-1:0]   next_data;

    wb_req_t alu_req, mem_req, sel;
    logic    starve_hit, alu_xfer, mem_xfer, id_legal;

    assign alu_req = '{valid: alu_valid, id: alu_id, data: alu_data};
    assign mem_req = '{valid: mem_valid, id: mem_id, data: mem_data};

    assign starve_hit = starve_cnt >= CNT_W'(STARVE_LIMIT);
    assign alu_xfer   = alu_req.valid && alu_ready;
    assign mem_xfer   = mem_req.valid && mem_ready;

    // The ready equations make the two transfers mutually exclusive.
    always_comb begin
        sel       = alu_xfer ? alu_req : mem_req;
        sel.valid = alu_xfer || mem_xfer;
    end

    // Id 0 is hardwired zero and out-of-range ids have no backing storage.
    assign id_legal = (sel.id != '0) &&
                      ({{(32-REG_ID_W){1'b0}}, sel.id} < 32'(REGISTER_FILE_SIZE));

    always_comb begin
        next_state = state;
        next_idx   = init_idx;
        next_cnt   = starve_cnt;
        next_en    = 1'b0;
        next_id    = rf_write_id;
        next_data  = rf_write_data;
        next_done  = init_done;
        alu_ready  = 1'b0;
        mem_ready  = 1'b0;
        case (state)
            WB_INIT: begin
                next_en   = 1'b1;
                next_id   = init_idx;
                next_data = '0;
                next_idx  = init_idx + 1'b1;
                if (init_idx == REG_ID_W'(REGISTER_FILE_SIZE - 1)) begin
                    next_done  = 1'b1;
                    next_state = WB_RUN;
                end
            end
            WB_RUN: begin
                mem_ready = !(alu_valid && starve_hit);
                alu_ready = !mem_valid || starve_hit;
                if (sel.valid) begin
                    next_en   = id_legal;
                    next_id   = sel.id;
                    next_data = sel.data;
                end
                if (alu_xfer || !alu_valid)
                    next_cnt = '0;
                else if (mem_xfer && !starve_hit)
                    next_cnt = starve_cnt + 1'b1;
            end
            default: next_state = WB_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WB_INIT;
            init_idx      <= REG_ID_W'(1);
            starve_cnt    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_id   <= '0;
            rf_write_data <= '0;
            init_done     <= 1'b0;
        end else begin
            state         <= next_state;
            init_idx      <= next_idx;
            starve_cnt    <= next_cnt;
            rf_write_en   <= next_en;
            rf_write_id   <= next_id;
            rf_write_data <= next_data;
            init_done     <= next_done;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and initialiser for the single write port of the 32-entry register file. After reset it sequences zero-writes into registers 1..31. It then arbitrates two write-back requesters onto the port: the ALU result path and the load/memory result path. It drives the register file write port (write_en, write_id, write_data) from registered outputs and sits between the execute/memory stages and the register file.

## Interface
- REGISTER_FILE_SIZE, 32: number of architectural registers; legal ids are 0..REGISTER_FILE_SIZE-1.
- STARVE_LIMIT, 4: consecutive lost arbitrations after which the ALU requester is forced to win once.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_id  in  6  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  memory/load write-back request.
- mem_ready  out  1  memory request accepted this cycle.
- mem_id  in  6  load destination register.
- mem_data  in  32  load result.
- rf_write_en  out  1  register file write enable (registered).
- rf_write_id  out  6  register file write index (registered).
- rf_write_data  out  32  register file write data (registered).
- init_done  out  1  high once the clear sequence has completed (registered).

## Operation
- States: WB_INIT and WB_RUN. Reset enters WB_INIT with init_idx=1.
- WB_INIT behaviour:
  - Each clock loads rf_write_en=1, rf_write_id=init_idx, rf_write_data=0, then increments init_idx.
  - When the load uses init_idx=REGISTER_FILE_SIZE-1, the same edge sets init_done=1 and moves to WB_RUN.
  - Both readys are 0 throughout WB_INIT.
- WB_RUN arbitration:
  - starve_hit = (starve_cnt >= STARVE_LIMIT).
  - mem_ready = !(alu_valid && starve_hit).
  - alu_ready = !mem_valid || starve_hit.
  - Readys are combinational and independent of the requester's own valid.
- Transfer: valid && ready on the same cycle. At most one transfer per cycle.
- starve_cnt update:
  - Increments, saturating at STARVE_LIMIT, when alu_valid && mem_valid && mem transfers.
  - Clears on an ALU transfer or when alu_valid=0.
- Write generation on the edge after a transfer:
  - rf_write_en = 1 if the accepted id is in 1..REGISTER_FILE_SIZE-1.
  - Ids 0 and >= REGISTER_FILE_SIZE complete the handshake but are dropped, so rf_write_en=0.
  - rf_write_id/rf_write_data load the accepted id/data on every transfer and otherwise hold.
- WB_RUN is terminal until reset.
- Requesters hold valid/id/data until ready; the block never back-pressures with ready=1 and then drops a write.

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - rf_write_en=0, rf_write_id=0, rf_write_data=0, init_done=0.
  - alu_ready=0, mem_ready=0, starve_cnt=0, state=WB_INIT, init_idx=1.
- Clear sequence:
  - Edge k after reset release (k=1..31) presents a write of id k with data 0.
  - init_done rises on edge 31.
  - The first accepted request can be in the cycle after edge 31; its write appears on edge 32.
- Latency: handshake cycle to write-port assertion is exactly 1 clock. Throughput is 1 write per clock.
- Reset mid-operation:
  - Outputs clear immediately.
  - Any accepted-but-unwritten transfer is discarded.
  - The clear sequence restarts from id 1.

## Structure
- Shared package regfile_pkg holds:
  - REGISTER_FILE_SIZE.
  - REG_ID_W=6.
  - typedef enum wb_state_t {WB_INIT, WB_RUN}.
  - typedef struct wb_req_t {valid, id, data}.
- The register file imports the same size constant.
- Single module, no sub-module: the FSM, saturating starve counter and output register are small enough to keep flat.

## Test plan
- Reset release, no requests -> edges 1..31 write ids 1..31 with data 0; init_done=1 at edge 31; readys 0 until then, then rf_write_en=0 at edge 32.
- After init, alu_valid=1, alu_id=5, alu_data=0xDEADBEEF -> alu_ready=1 the same cycle; next edge rf_write_en=1, rf_write_id=5, rf_write_data=0xDEADBEEF.
- Both valid continuously, mem ids 1,2,3,..., alu_id=7, STARVE_LIMIT=4:
  - mem wins 4 consecutive cycles; the 5th cycle alu_ready=1 and id 7 is written.
  - mem then wins 4 more before ALU wins again.
- alu_valid=1, alu_id=0, data=0x1234 -> alu_ready=1, handshake completes, rf_write_en stays 0; same for alu_id=40.
- Both valid in WB_RUN, reset_n pulsed low mid-cycle:
  - All outputs 0 immediately, init_done=0.
  - After release, the clear sequence restarts at id 1 and no pending write emerges.
- Requests asserted during WB_INIT (mem_id=9, data=0xA5) -> mem_ready=0 through edge 31; accepted the cycle after edge 31; id 9 written at edge 32 with 0xA5.
